// File: rtl/icache_l1_ctrl_if.sv
// Fetch-side, line-fill and data-array signals of the L1 instruction cache.
// slave: the cache controller; master: fetch stage, next level and data array.
interface icache_l1_ctrl_if #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_read;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_rdata;
  logic                  mem_resp;
  logic                  flush;
  logic                  pmem_read;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;
  logic                  array_write;
  logic [4:0]            array_index;
  logic [LINE_WIDTH-1:0] array_datain;
  logic [LINE_WIDTH-1:0] array_dataout;
  logic [31:0]           hit_count;
  logic [31:0]           miss_count;

  modport slave (
    input  mem_read, mem_address, flush,
    input  pmem_rdata, pmem_resp, array_dataout,
    output mem_rdata, mem_resp,
    output pmem_read, pmem_address,
    output array_write, array_index, array_datain,
    output hit_count, miss_count
  );

  modport master (
    output mem_read, mem_address, flush,
    output pmem_rdata, pmem_resp, array_dataout,
    input  mem_rdata, mem_resp,
    input  pmem_read, pmem_address,
    input  array_write, array_index, array_datain,
    input  hit_count, miss_count
  );
endinterface

// File: rtl/icache_l1_ctrl.sv
// Direct-mapped L1 I-cache controller: tag/valid state, hit check, line fill.
// Define ICACHE_PERF_CNT_EN to build the saturating hit/miss counters.
module icache_l1_ctrl #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  icache_l1_ctrl_if.slave bus
);
  localparam int TAG_W = ADDR_WIDTH - 10;

  typedef enum logic {
    CHECK,
    FILL
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [32];
  logic [TAG_W-1:0] tag_d [32];

  logic [4:0]            idx;
  logic [2:0]            word;
  logic [TAG_W-1:0]      req_tag;
  logic                  hit;
  logic [LINE_WIDTH-1:0] line;
  logic [1:0]            addr_unused;
  logic                  resp_c;
  logic                  awr_c;
  logic                  pmrd_c;

  assign idx         = bus.mem_address[9:5];
  assign word        = bus.mem_address[4:2];
  assign req_tag     = bus.mem_address[ADDR_WIDTH-1:10];
  assign addr_unused = bus.mem_address[1:0];
  assign line        = bus.array_dataout;
  assign hit         = valid_q[idx] && (tag_q[idx] == req_tag);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    resp_c  = 1'b0;
    awr_c   = 1'b0;
    pmrd_c  = 1'b0;
    unique case (state_q)
      CHECK: begin
        unique case (1'b1)
          bus.flush:
            valid_d = '0;
          !bus.flush && bus.mem_read && hit:
            resp_c = 1'b1;
          !bus.flush && bus.mem_read && !hit:
            state_d = FILL;
          default: ;
        endcase
      end
      FILL: begin
        pmrd_c = 1'b1;
        if (bus.pmem_resp) begin
          awr_c        = 1'b1;
          tag_d[idx]   = req_tag;
          valid_d[idx] = 1'b1;
          state_d      = CHECK;
        end
      end
      default: state_d = CHECK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CHECK;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  // Tags need no reset: valid bits alone gate hits.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  // A fill racing the reset cycle must not reach the array.
  assign bus.mem_resp     = resp_c && rst_n;
  assign bus.array_write  = awr_c && rst_n;
  assign bus.pmem_read    = pmrd_c;
  assign bus.mem_rdata    = line[32*word +: 32];
  assign bus.pmem_address = {bus.mem_address[ADDR_WIDTH-1:5], 5'b0};
  assign bus.array_index  = idx;
  assign bus.array_datain = bus.pmem_rdata;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        filled_q, filled_d;

  // The response right after a fill is a replay, not a first-try hit.
  always_comb begin
    filled_d   = (state_q == FILL) && bus.pmem_resp;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (bus.mem_resp && !filled_q && hit_cnt_q != '1)
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (state_q == CHECK && state_d == FILL && miss_cnt_q != '1)
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      filled_q   <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      filled_q   <= filled_d;
    end
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
`else
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif
endmodule
